mem_dumper: RTL
===============

MEM_DUMPER -- requirements
Module: mem_dumper

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of the memory read port.
REQ-002 SHALL have parameter DATA_W, default 32, memory word width.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a dump; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_W  first word address; sampled with start.
REQ-007 SHALL have port count  input  ADDR_W+1  number of words to dump; sampled with start.
REQ-008 SHALL have port mem_rd_en  output  1  memory read strobe.
REQ-009 SHALL have port mem_addr  output  ADDR_W  memory read word address.
REQ-010 SHALL have port mem_rd_data  input  DATA_W  read data, valid the cycle after mem_rd_en.
REQ-011 SHALL have port out_valid  output  1  dump stream word valid.
REQ-012 SHALL have port out_ready  input  1  dump stream consumer ready.
REQ-013 SHALL have port out_data  output  DATA_W  dumped word.
REQ-014 SHALL have port out_addr  output  ADDR_W  address of out_data.
REQ-015 SHALL have port out_last  output  1  high with the final word of a dump.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse at dump completion.

Function
REQ-018 SHALL implement the FSM states IDLE, READ, WAIT, SEND and DONE.
REQ-019 In IDLE, start=1 with count!=0 SHALL latch base_addr into cur_addr and count into remaining, then go to READ.
REQ-020 In IDLE, start=1 with count==0 SHALL go directly to DONE, with no memory read and no stream word.
REQ-021 In READ, mem_rd_en SHALL be 1 and mem_addr SHALL be cur_addr for exactly one cycle; next state SHALL be WAIT.
REQ-022 In WAIT, mem_rd_data SHALL be registered into out_data, cur_addr into out_addr, and (remaining==1) into out_last; next state SHALL be SEND.
REQ-023 In SEND, out_valid SHALL be 1; a transfer occurs on a cycle where out_valid=1 and out_ready=1.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_addr and out_last SHALL hold stable.
REQ-025 On a transfer with remaining==1, the FSM SHALL go to DONE; otherwise cur_addr SHALL increment, remaining SHALL decrement, and the FSM SHALL go to READ.
REQ-026 cur_addr SHALL wrap modulo 2^ADDR_W (for example, 0xFF+1 -> 0x00 at ADDR_W=8).
REQ-027 In DONE, done SHALL be 1 for exactly one cycle; next state SHALL be IDLE.
REQ-028 start SHALL be ignored in every state other than IDLE.
REQ-029 Latency: with start sampled at edge k, mem_rd_en SHALL be high in cycle k+1 and out_valid SHALL first be high in cycle k+3.
REQ-030 With out_ready held at 1, words SHALL be emitted every 3 cycles, and done SHALL be high in the cycle after the last transfer.
REQ-031 mem_rd_en SHALL be 0 outside READ, and out_valid SHALL be 0 outside SEND.
REQ-032 count equal to 2^ADDR_W SHALL dump the full memory, with the wrap-around of REQ-026 applied.

Reset
REQ-033 reset=1 SHALL, at the next edge, force state to IDLE and zero every output and internal register, including mid-dump.
REQ-034 A pending stream word SHALL be dropped by reset, and no done pulse SHALL follow a reset.
REQ-035 start asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-036 Bench SHALL preload mem[i]=i; start, base_addr=4, count=3, out_ready=1 -> words 4,5,6 at out_addr 4,5,6; out_last only on 6; done pulses once, 1 cycle after the third transfer.
REQ-037 Bench SHALL run start, count=0 -> done pulses in cycle k+1; mem_rd_en and out_valid stay 0 throughout.
REQ-038 Bench SHALL run base_addr=0xFE, count=3 -> out_addr sequence 0xFE, 0xFF, 0x00.
REQ-039 Bench SHALL hold out_ready=0 for 5 cycles during the first word -> out_valid stays 1 and out_data stays stable; no second mem_rd_en occurs until after the transfer.
REQ-040 Bench SHALL assert reset in SEND of the 2nd of 4 words -> next cycle busy=0, out_valid=0, done=0; a new start, base_addr=0, count=1, yields word 0 only.
REQ-041 Bench SHALL pulse start again while busy -> ignored; dump length remains the original count.

Source files
------------

// File: rtl/mem_dumper.sv
// Streams a contiguous range of memory words out over a valid/ready port,
// one word per read/wait/send round trip.
module mem_dumper #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] READ = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] SEND = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [ADDR_W:0]   CNT_ZERO = '0;
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   remaining;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != CNT_ZERO) begin
                            cur_addr  <= base_addr;
                            remaining <= count;
                            state     <= READ;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                READ: state <= WAIT;
                WAIT: begin
                    // Memory returns data one cycle after the strobe.
                    out_data <= mem_rd_data;
                    out_addr <= cur_addr;
                    out_last <= (remaining == CNT_ONE);
                    state    <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        if (remaining == CNT_ONE) begin
                            state <= DONE;
                        end else begin
                            cur_addr  <= cur_addr + ADDR_ONE;
                            remaining <= remaining - CNT_ONE;
                            state     <= READ;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_rd_en = (state == READ);
    assign mem_addr  = mem_rd_en ? cur_addr : '0;
    assign out_valid = (state == SEND);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule
